// File: rtl/nn_pkg.sv
// Shared neural-network layer definitions: default datapath sizes, the
// scatter FSM state type, and the element-index width helper.
package nn_pkg;

    localparam int NN_WIDTH      = 16;
    localparam int NN_INPUT_SIZE = 10;

    typedef enum logic {
        IDLE,
        STREAM
    } scatter_state_t;

    // An index must always be at least one bit wide, even for a single element.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/weighted_scatter_if.sv
// Handshake bundle for weighted_scatter: vector input side and element output side.
interface weighted_scatter_if
    import nn_pkg::*;
#(
    parameter int WIDTH      = NN_WIDTH,
    parameter int INPUT_SIZE = NN_INPUT_SIZE,
    parameter int IDX_W      = idx_width(INPUT_SIZE)
);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] delta;
    logic [WIDTH-1:0] weights [INPUT_SIZE];
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDX_W-1:0] out_idx;
    logic             out_last;
    logic             busy;

    modport slave (
        input  in_valid, delta, weights, out_ready,
        output in_ready, out_valid, out_data, out_idx, out_last, busy
    );

    modport master (
        output in_valid, delta, weights, out_ready,
        input  in_ready, out_valid, out_data, out_idx, out_last, busy
    );

endinterface

// File: rtl/trunc_mul.sv
// Unsigned WIDTH x WIDTH multiply keeping only the low WIDTH bits (modulo 2^WIDTH).
module trunc_mul #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] p
);

    // A WIDTH-bit context yields exactly the low half of the full product.
    assign p = a * b;

endmodule

// File: rtl/weighted_scatter.sv
// Backward-path scatter: latches one delta plus a weight vector and streams
// delta * weights[i] (mod 2^WIDTH), one element per output handshake.
module weighted_scatter
    import nn_pkg::*;
#(
    parameter int INPUT_SIZE = NN_INPUT_SIZE,
    parameter int WIDTH      = NN_WIDTH,
    parameter int IDX_W      = idx_width(INPUT_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    weighted_scatter_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(INPUT_SIZE - 1);

    scatter_state_t   state;
    logic [IDX_W-1:0] idx;
    logic             last;
    logic [WIDTH-1:0] delta_r;
    logic [WIDTH-1:0] w_r [INPUT_SIZE];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            last    <= 1'b0;
            delta_r <= '0;
            for (int i = 0; i < INPUT_SIZE; i++) begin
                w_r[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        delta_r <= bus.delta;
                        w_r     <= bus.weights;
                        idx     <= '0;
                        last    <= (INPUT_SIZE == 1);
                        state   <= STREAM;
                    end
                end
                STREAM: begin
                    // The held vector is only replaced from IDLE, so inputs here are ignored.
                    if (bus.out_ready) begin
                        if (last) begin
                            idx   <= '0;
                            last  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            idx  <= idx + IDX_W'(1);
                            last <= ((idx + IDX_W'(1)) == LAST_IDX);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Handshake outputs come straight from registered state, never from out_ready/in_valid.
    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = (state == STREAM);
    assign bus.busy      = (state == STREAM);
    assign bus.out_idx   = idx;
    assign bus.out_last  = last;

    trunc_mul #(
        .WIDTH(WIDTH)
    ) u_mul (
        .a(delta_r),
        .b(w_r[idx]),
        .p(bus.out_data)
    );

endmodule

// File: tb/tb_weighted_scatter.sv
// Directed self-checking bench for weighted_scatter (INPUT_SIZE=10, WIDTH=16).
module tb_weighted_scatter;

    localparam int N = 10;

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk = 0;
    int   n_bad = 0;

    logic [15:0] mw [N];

    weighted_scatter_if #(.WIDTH(16), .INPUT_SIZE(N)) bus ();

    weighted_scatter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Present a vector at a falling edge; returns one cycle later with element 0 on the bus.
    task automatic send(input logic [15:0] d);
        chk("in_ready_before_send", bus.in_ready, 1'b1);
        bus.delta     = d;
        for (int i = 0; i < N; i++) bus.weights[i] = mw[i];
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.in_valid  = 1'b0;
    endtask

    // Walk the stream; expected product uses 32-bit math truncated to 16 bits,
    // plus one hand-computed constant at index hc_idx.
    task automatic stream_check(input logic [15:0] d, input int bp_at, input int bp_len,
                                input int abort_at, input int hc_idx, input logic [15:0] hc_val);
        logic [31:0] full;
        for (int i = 0; i < N; i++) begin
            full = 32'(d) * 32'(mw[i]);
            chk("out_valid", bus.out_valid, 1'b1);
            chk("busy", bus.busy, 1'b1);
            chk("in_ready_stream", bus.in_ready, 1'b0);
            chk("out_idx", bus.out_idx, i);
            chk("out_data", bus.out_data, full[15:0]);
            chk("out_last", bus.out_last, (i == N - 1));
            if (i == hc_idx) chk("hand_val", bus.out_data, hc_val);
            if (i == abort_at) begin
                #2 rst_n = 1'b0;
                #1;
                chk("abort_out_valid", bus.out_valid, 1'b0);
                chk("abort_in_ready", bus.in_ready, 1'b1);
                chk("abort_out_idx", bus.out_idx, 0);
                chk("abort_out_last", bus.out_last, 1'b0);
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (i == bp_at) begin
                bus.out_ready = 1'b0;
                repeat (bp_len) begin
                    @(negedge clk);
                    chk("bp_valid", bus.out_valid, 1'b1);
                    chk("bp_idx", bus.out_idx, i);
                    chk("bp_data", bus.out_data, full[15:0]);
                    chk("bp_last", bus.out_last, 1'b0);
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("done_out_valid", bus.out_valid, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.delta     = '0;
        for (int i = 0; i < N; i++) bus.weights[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_data", bus.out_data, 16'h0000);
        chk("rst_out_idx", bus.out_idx, 0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // Basic: 3 * i
        for (int i = 0; i < N; i++) mw[i] = 16'(i);
        send(16'd3);
        stream_check(16'd3, -1, 0, -1, 9, 16'd27);

        // Backpressure for 3 cycles at idx 4
        send(16'd3);
        stream_check(16'd3, 4, 3, -1, 5, 16'd15);

        // Wrap: 0x0100 * 0x0100 -> 0
        mw[0] = 16'h0100;
        for (int i = 1; i < N; i++) mw[i] = 16'(i);
        send(16'h0100);
        stream_check(16'h0100, -1, 0, -1, 0, 16'h0000);

        // Wrap: 0xFFFF * 0xFFFF -> 1
        mw[0] = 16'h0002;
        mw[1] = 16'hFFFF;
        send(16'hFFFF);
        stream_check(16'hFFFF, -1, 0, -1, 1, 16'h0001);

        // Ignored input during STREAM, then accepted right after the last element
        for (int i = 0; i < N; i++) mw[i] = 16'(i + 1);
        send(16'd5);
        bus.in_valid = 1'b1;
        bus.delta    = 16'd7;
        for (int i = 0; i < N; i++) bus.weights[i] = 16'(i);
        stream_check(16'd5, -1, 0, -1, 9, 16'd50);
        chk("held_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        for (int i = 0; i < N; i++) mw[i] = 16'(i);
        stream_check(16'd7, -1, 0, -1, 3, 16'd21);

        // Reset mid-stream at idx 5, then a fresh vector starts at idx 0
        send(16'd3);
        stream_check(16'd3, -1, 0, 5, -1, 16'd0);
        chk("post_rst_in_ready", bus.in_ready, 1'b1);
        chk("post_rst_busy", bus.busy, 1'b0);
        send(16'd2);
        stream_check(16'd2, -1, 0, -1, 0, 16'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule

// File: doc/weighted_scatter.md
# weighted_scatter

Transposed counterpart of the neuron weighted-sum datapath. It accepts one scalar (an output-side error/delta term) plus the neuron's weight vector, and streams the per-input products `delta * weights[i]` back toward the input side, one element per handshake. It sits on the backward path of the neural-network layer, opposite the combinational weighted-sum block, and uses the same unsigned, modulo-2^WIDTH arithmetic.

## Interface
- `INPUT_SIZE`, default 10: number of weights and output elements per transaction (≥1).
- `WIDTH`, default 16: data, weight and product width.
- `IDX_W`, default `$clog2(INPUT_SIZE)` (minimum 1): element index width.

- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  delta and weights presented.
- `in_ready`  out  1  block can accept a new vector.
- `delta`  in  WIDTH  scalar multiplier (unsigned).
- `weights`  in  WIDTH × INPUT_SIZE (unpacked array)  weight vector (unsigned).
- `out_valid`  out  1  `out_data` holds a valid element.
- `out_ready`  in  1  downstream accepts the element.
- `out_data`  out  WIDTH  `(delta_r * w_r[out_idx])` mod 2^WIDTH.
- `out_idx`  out  IDX_W  index of the current element, 0..INPUT_SIZE-1.
- `out_last`  out  1  high with `out_valid` when `out_idx == INPUT_SIZE-1`.
- `busy`  out  1  high in STREAM.

## Operation
- FSM states: IDLE, STREAM.
- **IDLE**
  - `in_ready=1`, `out_valid=0`.
  - On `in_valid && in_ready`: register `delta` into `delta_r` and all weights into `w_r[]`, set `idx=0`, go to STREAM.
- **STREAM**
  - `in_ready=0`, `out_valid=1`.
  - `out_data` is computed from registered state only.
  - On `out_valid && out_ready`:
    - If `idx == INPUT_SIZE-1`, go to IDLE.
    - Otherwise `idx <= idx+1`.
- **Arithmetic:** full product is 2·WIDTH bits; keep the low WIDTH bits. No saturation and no sign handling.
- **Inputs during STREAM:** `in_valid`, `delta` and `weights` are ignored; the held vector is unaffected.
- **INPUT_SIZE=1:** `out_last` is high on the only element.
- **No overlap:** a new vector is accepted only after the last element handshake.
- **Reset:** `rst_n` low at any time, including mid-stream, immediately forces IDLE and aborts the stream. No partial resume; the remaining elements are discarded.
- **Reset values:**
  - `in_ready=1`
  - `out_valid=0`, `out_data=0`, `out_idx=0`, `out_last=0`
  - `busy=0`, `delta_r=0`, `w_r[]=0`

## Timing
- Accept edge N → `out_valid=1` with element 0 after edge N (visible in cycle N+1).
- One element per cycle while `out_ready=1`. A vector occupies INPUT_SIZE+1 cycles minimum, including the accept cycle.
- Last handshake at edge M → `in_ready=1` in cycle M+1.
- **Backpressure:** while `out_valid && !out_ready`, `out_data`, `out_idx` and `out_last` are held stable.
- `out_valid` never drops without a handshake, except on reset.
- `in_ready` depends only on state; there is no combinational path from `in_valid` or `out_ready` to `in_ready`.
- `out_valid` does not depend combinationally on `out_ready`.

## Structure
- Shared package `nn_pkg`:
  - FSM state typedef (`scatter_state_t`: IDLE, STREAM).
  - Index-width helper function.
  - Default WIDTH/INPUT_SIZE constants shared with the weighted-sum datapath.
- Single module. Optionally split off one sub-module `trunc_mul` (WIDTH×WIDTH → low WIDTH bits) so it can be shared with the forward path.

## Test plan
- **Reset:** assert `rst_n=0` → `in_ready=1`, `out_valid=0`, `out_data=0`, `out_idx=0`, `busy=0`.
- **Basic stream:** `delta=3`, `weights=0..9`, `out_ready=1` throughout → `out_data` 0,3,6,…,27 on `out_idx` 0..9 in consecutive cycles; `out_last` only at idx 9; `in_ready=1` the following cycle.
- **Backpressure:** same vector, drop `out_ready` for 3 cycles while `out_idx=4` → `out_data=12`, `out_idx=4` held stable; stream resumes at 15 with no skipped or duplicated elements.
- **Wrap:** `delta=16'h0100`, `w[0]=16'h0100` → 0x0000. `delta=16'hFFFF`, `w[1]=16'hFFFF` → 0x0001.
- **Ignored input:** new `in_valid` with `delta=7` during STREAM → ignored, current products unchanged. Hold `in_valid` through the last handshake → accepted in the IDLE cycle; next stream outputs multiples of 7 starting at idx 0.
- **Reset mid-stream:** assert reset at `out_idx=5` → `out_valid` falls immediately. After release: IDLE with `in_ready=1`, and the next vector starts at idx 0.
